// File: rtl/rd_hold_buf_if.sv
// Handshake bundle for rd_hold_buf: producer write side and
// four-phase rd/rd_ack consumer side.
interface rd_hold_buf_if #(
   parameter int WIDTH = 4
);
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             rd;
   logic [WIDTH-1:0] data_out;
   logic             rd_ack;

   modport master (
      output wr_valid,
      output wr_data,
      output rd_ack,
      input  wr_ready,
      input  rd,
      input  data_out
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      input  rd_ack,
      output wr_ready,
      output rd,
      output data_out
   );
endinterface

// File: rtl/rd_hold_buf.sv
// Single-entry hold buffer: accepts one beat, presents it on a
// four-phase rd/rd_ack handshake, and tracks ack latency and errors.
module rd_hold_buf #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   rd_hold_buf_if.slave bus,
   output logic [7:0] ack_lat,
   output logic       timeout_err,
   output logic       proto_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK_LOW
   } state_t;

   localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

   state_t           state;
   state_t           state_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [7:0]       lat_d;
   logic [8:0]       lat_inc;
   logic             te_d;
   logic             pe_d;

   always_comb begin
      state_d = state;
      data_d  = data_q;
      lat_d   = ack_lat;
      te_d    = timeout_err;
      pe_d    = proto_err;
      lat_inc = {1'b0, ack_lat} + 9'd1;
      unique case (state)
         IDLE: begin
            // ack with nothing outstanding is flagged, but never blocks an accept
            if (bus.rd_ack)
               pe_d = 1'b1;
            if (bus.wr_valid) begin
               data_d  = bus.wr_data;
               lat_d   = 8'd0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.rd_ack) begin
               state_d = ACK_LOW;
            end else begin
               if (ack_lat != 8'hFF)
                  lat_d = lat_inc[7:0];
               if (lat_inc == TO_LIM)
                  te_d = 1'b1;
            end
         end
         ACK_LOW: begin
            if (!bus.rd_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         data_q      <= '0;
         ack_lat     <= 8'd0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         state       <= state_d;
         data_q      <= data_d;
         ack_lat     <= lat_d;
         timeout_err <= te_d;
         proto_err   <= pe_d;
      end
   end

   assign bus.wr_ready = (state == IDLE);
   assign bus.rd       = (state == REQ);
   assign bus.data_out = data_q;

endmodule

// File: doc/rd_hold_buf.md
RD_HOLD_BUF -- requirements
Module: rd_hold_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles in REQ before rd_ack is flagged late; legal range 1..255.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 wr_valid  input  1  producer offers wr_data.
REQ-007 wr_data  input  WIDTH  producer data.
REQ-008 wr_ready  output  1  single entry empty; a beat is accepted when wr_valid && wr_ready.
REQ-009 rd  output  1  read request / start event to the consumer; high while data_out is valid and held.
REQ-010 data_out  output  WIDTH  held data; stable from rd rising until the cycle after rd_ack is sampled high.
REQ-011 rd_ack  input  1  consumer acknowledge / end event.
REQ-012 ack_lat  output  8  cycles spent in REQ for the current or last transfer; saturates at 255.
REQ-013 timeout_err  output  1  sticky; set when the REQ duration reaches TIMEOUT.
REQ-014 proto_err  output  1  sticky; set when rd_ack is high while in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and ACK_LOW.
REQ-016 IDLE: wr_ready=1 and rd=0; on wr_valid=1 the block SHALL load data_out<=wr_data, clear ack_lat to 0 and go to REQ.
REQ-017 Latency: rd SHALL rise on the clock edge that accepts the beat, so rd is visible in the cycle after the accept cycle.
REQ-018 REQ: rd=1 and wr_ready=0; data_out SHALL NOT change, and wr_valid SHALL be ignored.
REQ-019 REQ with rd_ack=0: ack_lat SHALL increment by 1, saturating at 255.
REQ-020 REQ with rd_ack=0 and ack_lat+1 == TIMEOUT: timeout_err SHALL be set; the state SHALL remain REQ and data SHALL stay held.
REQ-021 REQ with rd_ack=1: the block SHALL go to ACK_LOW with rd=0 from the next cycle, and ack_lat SHALL freeze.
REQ-022 ACK_LOW: rd=0 and wr_ready=0; the block SHALL wait for rd_ack=0, then go to IDLE. This is a four-phase handshake: rd and rd_ack both return low before the next transfer.
REQ-023 In ACK_LOW, data_out SHALL retain its last value until the next accept.
REQ-024 IDLE with rd_ack=1: proto_err SHALL be set and the state SHALL be unchanged; if wr_valid=1 in the same cycle, the beat SHALL still be accepted.
REQ-025 Back-to-back transfers: at least one IDLE cycle SHALL separate consecutive transfers, so the minimum period is REQ(>=1) + ACK_LOW(>=1) + IDLE(1) cycles.
REQ-026 All outputs SHALL be registered; wr_ready SHALL be decoded directly from the state register.
REQ-027 timeout_err and proto_err SHALL clear only on reset.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL go to IDLE with rd=0, wr_ready=1, data_out=0, ack_lat=0, timeout_err=0 and proto_err=0.
REQ-029 Reset SHALL override all state, including mid-REQ or mid-ACK_LOW; the held data is discarded.
REQ-030 wr_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-031 Basic transfer: wr_data=4'hF with wr_valid for 1 cycle; rd_ack=1 after 5 cycles of rd; rd_ack=0 2 cycles later -> rd high for 5+1 cycles, data_out=4'hF throughout, ack_lat=5, wr_ready returns 1 one cycle after rd_ack falls, no errors.
REQ-032 Hold stability: during REQ, drive wr_valid=1 with wr_data=4'h3 -> data_out stays 4'hC (the loaded value), wr_ready=0, nothing accepted.
REQ-033 Timeout: accept 4'hA, never assert rd_ack -> timeout_err rises after 16 REQ cycles, rd stays 1, data_out stays 4'hA; a later rd_ack completes the transfer normally.
REQ-034 Protocol error: rd_ack=1 in IDLE with wr_valid=0 -> proto_err=1 next cycle, state stays IDLE; the flag persists until reset.
REQ-035 Reset mid-operation: reset=1 for 1 cycle while in REQ with data 4'h5 -> next cycle rd=0, data_out=0, wr_ready=1, ack_lat=0, flags cleared.
REQ-036 Back-to-back: two beats, 4'h1 then 4'h2, with rd_ack delayed by 1 cycle -> each value is held for its whole window, and rd is low for at least 2 cycles between the two rd windows.
